// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and store/error helpers for the data-memory responder.
package dmem_pkg;

  // RV32I load/store funct3 encodings (stores use F3_B/F3_H/F3_W only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misalignment or an unsupported funct3 for the given direction.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    err = 1'b0;
        F3_H:    err = addr_lo[0];
        F3_W:    err = (addr_lo != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = addr_lo[0];
        F3_W:        err = (addr_lo != 2'b00);
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

  // Byte lanes touched by a store.
  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes so any lane can pick it up.
  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data extraction: picks the addressed byte/halfword and sign- or zero-extends it.
module load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection from the low address bits
  always_comb begin
    sel_byte = word[7:0];
    case (addr_lo)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extension by access type; unsupported encodings return zero
  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   result = {24'h0, sel_byte};
      F3_H:    result = {{16{sel_half[15]}}, sel_half};
      F3_HU:   result = {16'h0, sel_half};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
//
// state | meaning
// IDLE  | ready for a request; accepting latches the request fields
// WAIT  | wait states counting down before the memory access
// RESP  | access committed; response held until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Counter reload value: WAIT lasts reload+1 cycles, exiting when the count is zero
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] wait_cnt;

  logic              lat_we;
  logic [2:0]        lat_funct3;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              accept;
  logic              commit;
  logic              acc_we;
  logic [2:0]        acc_funct3;
  logic [ADDR_W+1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_index;
  logic              acc_err;
  logic [3:0]        acc_be;
  logic [31:0]       acc_lanes;
  logic [31:0]       mem_word;
  logic [31:0]       load_data;

  logic [31:0] mem [DEPTH];

  // Upper address bits only alias the memory, so they are intentionally dropped
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // Next-state logic; commit marks the edge that enters RESP
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so the
  // live request fields are used there instead of the latched copy
  always_comb begin
    if (state == IDLE) begin
      acc_we     = req_we;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr[ADDR_W+1:0];
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = lat_we;
      acc_funct3 = lat_funct3;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
    end
  end

  // Access decode shared by the read and write paths
  always_comb begin
    acc_index = acc_addr[ADDR_W+1:2];
    acc_err   = access_err(acc_we, acc_funct3, acc_addr[1:0]);
    acc_be    = store_be(acc_funct3, acc_addr[1:0]);
    acc_lanes = store_lanes(acc_funct3, acc_wdata);
    mem_word  = mem[acc_index];
  end

  load_align u_load_align (
    .funct3  (acc_funct3),
    .addr_lo (acc_addr[1:0]),
    .word    (mem_word),
    .result  (load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Wait-state down-counter, loaded on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Request capture; only an accepted request may update these
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
    end else if (accept) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr[ADDR_W+1:0];
      lat_wdata  <= req_wdata;
    end
  end

  // Response registers: loaded at commit, held through RESP, cleared on consume
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || acc_we) ? 32'h0 : load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end
  end

  // Memory write with per-lane enables; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && commit && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_index][8*i +: 8] <= acc_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15, meaning wait states inserted between request acceptance and the memory access.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I funct3 access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned access or illegal funct3.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req_valid=1 SHALL latch we, funct3, addr and wdata, and SHALL move the FSM to WAIT (WAIT_CYCLES>0) or to RESP (WAIT_CYCLES=0).
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter, before the FSM moves to RESP.
REQ-018 The memory read or write SHALL commit on the edge that enters RESP, so rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay high and stable until rsp_valid&rsp_ready; that edge SHALL return the FSM to IDLE and clear rsp_valid.
REQ-020 A new request SHALL NOT be accepted on the same edge a response is consumed; the minimum spacing between transactions is WAIT_CYCLES+2 cycles.
REQ-021 The word index SHALL be req_addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo the memory size.
REQ-022 LB/LBU SHALL select the byte given by addr[1:0]; LB sign-extends bit 7 and LBU zero-extends.
REQ-023 LH/LHU SHALL select the halfword given by addr[1]; LH sign-extends and LHU zero-extends.
REQ-024 LW SHALL return the full word.
REQ-025 SB/SH/SW SHALL write only the addressed byte lanes; all other lanes SHALL be preserved.
REQ-026 The access SHALL be flagged as an error (rsp_err=1, no write, rsp_rdata=0) when any of the following holds:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 >010.
REQ-027 req_valid while the FSM is not in IDLE SHALL be ignored, and the latched fields SHALL NOT change.

Reset
REQ-028 While reset=1, on each edge the FSM SHALL go to IDLE, req_ready SHALL be 0, and rsp_valid, rsp_err, rsp_rdata and the wait counter SHALL be 0.
REQ-029 req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-030 A reset in WAIT SHALL abandon the transaction with no memory write; a reset in RESP SHALL drop the response.
REQ-031 Reset SHALL NOT clear memory contents.

Structure
REQ-032 Package dmem_pkg SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum (IDLE, WAIT, RESP).
REQ-033 Load byte/half selection and extension SHALL live in one combinational sub-module, load_align (inputs funct3, addr[1:0], word; output 32-bit result).
REQ-034 The memory SHALL be a 2**ADDR_W x 32 array with a single access per transaction.

Verification
REQ-035 With WAIT_CYCLES=1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-036 After that store, LB 0x13 -> 0xFFFFFFDE, LBU 0x13 -> 0x000000DE, LH 0x12 -> 0xFFFFDEAD, LHU 0x10 -> 0x0000BEEF.
REQ-037 SB 0x11 data 0x55 over word 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-038 LW 0x22 -> rsp_err=1, rsp_rdata=0; a subsequent LW 0x20 shows the memory unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, extra req_valid ignored.
REQ-040 Assert reset during WAIT of SW 0x30 data 0x1 -> next cycle all outputs 0, and a later LW 0x30 returns the prior value.
